// File: rtl/ltl_monitor_sequencer_if.sv
// Trace-symbol, automaton-control and report-record signals of ltl_monitor_sequencer.
// slave = sequencer side, master = environment side.
interface ltl_monitor_sequencer_if #(
   parameter int unsigned NUM_REPORTS = 4,
   parameter int unsigned IDX_W       = 16
);
   logic                   sym_valid;
   logic [7:0]             sym_data;
   logic                   sym_ready;
   logic                   trace_start;
   logic                   trace_end;
   logic                   aut_reset;
   logic                   aut_run;
   logic [7:0]             aut_symbols;
   logic [NUM_REPORTS-1:0] aut_report;
   logic                   rpt_valid;
   logic                   rpt_ready;
   logic [IDX_W-1:0]       rpt_index;
   logic [NUM_REPORTS-1:0] rpt_bits;
   logic                   busy;
   logic                   violation;

   modport slave (
      input  sym_valid, sym_data, trace_start, trace_end, aut_report, rpt_ready,
      output sym_ready, aut_reset, aut_run, aut_symbols, rpt_valid, rpt_index, rpt_bits,
             busy, violation
   );

   modport master (
      output sym_valid, sym_data, trace_start, trace_end, aut_report, rpt_ready,
      input  sym_ready, aut_reset, aut_run, aut_symbols, rpt_valid, rpt_index, rpt_bits,
             busy, violation
   );
endinterface

// File: rtl/ltl_monitor_sequencer.sv
// Sequences a symbol trace into an LTL monitor automaton and collects its nonzero reports.
// Optional macro LTL_SEQ_RPT_FIFO_EN: 4-entry report FIFO instead of a single report register.
module ltl_monitor_sequencer #(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned NUM_REPORTS = 4,
   parameter int unsigned IDX_W       = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   ltl_monitor_sequencer_if.slave bus
);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned RCNT_W = 3;
`ifdef LTL_SEQ_RPT_FIFO_EN
   localparam int unsigned RPT_DEPTH = 4;
`else
   localparam int unsigned RPT_DEPTH = 1;
`endif

   typedef enum logic [1:0] {IDLE, RST, RUN, DRAIN} state_t;

   state_t state, state_nxt;
   logic   rst_cnt;

   logic [7:0]        sym_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  sym_cnt;
   logic [IDX_W-1:0]  idx, run_idx, samp_idx;
   logic              aut_run_q, samp_q, violation_q;
   logic [7:0]        aut_symbols_q;
   logic [RCNT_W-1:0] rpt_cnt;

   logic              fifo_full_c, fifo_empty_c, accepting_c, stepping_c;
   logic              sym_push_c, step_c, rpt_push_c, rpt_pop_c;
   logic [RCNT_W-1:0] committed_c;

   assign fifo_full_c  = (sym_cnt == CNT_W'(FIFO_DEPTH));
   assign fifo_empty_c = (sym_cnt == '0);
   assign accepting_c  = (state == RST) || (state == RUN);
   assign stepping_c   = (state == RUN) || (state == DRAIN);
   assign sym_push_c   = bus.sym_valid && accepting_c && !fifo_full_c;
   // Every step still in flight may yield a record, so its slot space is reserved up front.
   assign committed_c  = rpt_cnt + RCNT_W'(aut_run_q) + RCNT_W'(samp_q);
   assign step_c       = stepping_c && !fifo_empty_c && (committed_c < RCNT_W'(RPT_DEPTH));
   assign rpt_push_c   = samp_q && (bus.aut_report != '0);
   assign rpt_pop_c    = bus.rpt_valid && bus.rpt_ready;

   assign bus.sym_ready   = accepting_c && !fifo_full_c;
   assign bus.aut_reset   = (state == IDLE) || (state == RST);
   assign bus.busy        = (state != IDLE);
   assign bus.aut_run     = aut_run_q;
   assign bus.aut_symbols = aut_symbols_q;
   assign bus.violation   = violation_q;

   // State register; rst_cnt counts the two automaton-reset cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         rst_cnt <= 1'b0;
      end else begin
         state   <= state_nxt;
         rst_cnt <= (state == RST) && !bus.trace_start && !rst_cnt;
      end
   end

   // Next-state logic; trace_start overrides everything, including trace_end.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = IDLE;
         RST:     if (rst_cnt) state_nxt = RUN;
         RUN:     if (bus.trace_end) state_nxt = DRAIN;
         DRAIN:   if (fifo_empty_c && !aut_run_q && !samp_q) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (bus.trace_start) state_nxt = RST;
   end

   always_ff @(posedge clk) begin
      if (sym_push_c) sym_mem[wr_ptr] <= bus.sym_data;
   end

   // Symbol FIFO pointers, step pipeline and index; trace_start flushes like reset.
   always_ff @(posedge clk) begin
      if (reset || bus.trace_start) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         sym_cnt     <= '0;
         idx         <= '0;
         run_idx     <= '0;
         samp_idx    <= '0;
         aut_run_q   <= 1'b0;
         samp_q      <= 1'b0;
         violation_q <= 1'b0;
      end else begin
         if (sym_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (step_c) begin
            rd_ptr  <= rd_ptr + PTR_W'(1);
            run_idx <= idx;
            if (idx != '1) idx <= idx + IDX_W'(1);
         end
         sym_cnt   <= sym_cnt + CNT_W'(sym_push_c) - CNT_W'(step_c);
         aut_run_q <= step_c;
         samp_q    <= aut_run_q;
         samp_idx  <= run_idx;
         if (rpt_push_c) violation_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)       aut_symbols_q <= '0;
      else if (step_c && !bus.trace_start) aut_symbols_q <= sym_mem[rd_ptr];
   end

`ifdef LTL_SEQ_RPT_FIFO_EN
   logic [IDX_W-1:0]       rq_idx  [RPT_DEPTH];
   logic [NUM_REPORTS-1:0] rq_bits [RPT_DEPTH];
   logic [1:0]             rq_wr, rq_rd;

   // Report FIFO; storage cleared so rpt_index/rpt_bits read zero when empty after reset.
   always_ff @(posedge clk) begin
      if (reset || bus.trace_start) begin
         rq_wr   <= '0;
         rq_rd   <= '0;
         rpt_cnt <= '0;
         for (int i = 0; i < int'(RPT_DEPTH); i++) begin
            rq_idx[i]  <= '0;
            rq_bits[i] <= '0;
         end
      end else begin
         if (rpt_push_c) begin
            rq_idx[rq_wr]  <= samp_idx;
            rq_bits[rq_wr] <= bus.aut_report;
            rq_wr          <= rq_wr + 2'd1;
         end
         if (rpt_pop_c) rq_rd <= rq_rd + 2'd1;
         rpt_cnt <= rpt_cnt + RCNT_W'(rpt_push_c) - RCNT_W'(rpt_pop_c);
      end
   end

   assign bus.rpt_valid = (rpt_cnt != '0);
   assign bus.rpt_index = rq_idx[rq_rd];
   assign bus.rpt_bits  = rq_bits[rq_rd];
`else
   logic                   rpt_valid_q;
   logic [IDX_W-1:0]       rpt_index_q;
   logic [NUM_REPORTS-1:0] rpt_bits_q;

   // Single report register; held unchanged while waiting for rpt_ready.
   always_ff @(posedge clk) begin
      if (reset || bus.trace_start) begin
         rpt_valid_q <= 1'b0;
         rpt_index_q <= '0;
         rpt_bits_q  <= '0;
      end else if (rpt_push_c) begin
         rpt_valid_q <= 1'b1;
         rpt_index_q <= samp_idx;
         rpt_bits_q  <= bus.aut_report;
      end else if (rpt_pop_c) begin
         rpt_valid_q <= 1'b0;
      end
   end

   assign rpt_cnt       = RCNT_W'(rpt_valid_q);
   assign bus.rpt_valid = rpt_valid_q;
   assign bus.rpt_index = rpt_index_q;
   assign bus.rpt_bits  = rpt_bits_q;
`endif

endmodule

// File: doc/ltl_monitor_sequencer.md
LTL_MONITOR_SEQUENCER -- requirements
Module: ltl_monitor_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning symbol FIFO entries (power of 2, at least 2).
REQ-002 SHALL have parameter NUM_REPORTS, default 4, meaning automaton report-vector width.
REQ-003 SHALL have parameter IDX_W, default 16, meaning symbol-index counter width.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port sym_valid  input  1  trace symbol offered.
REQ-007 SHALL have port sym_data  input  8  trace symbol.
REQ-008 SHALL have port sym_ready  output  1  symbol accepted when sym_valid and sym_ready are both high.
REQ-009 SHALL have port trace_start  input  1  single-cycle pulse that begins a new trace.
REQ-010 SHALL have port trace_end  input  1  single-cycle pulse: no further symbols follow.
REQ-011 SHALL have port aut_reset  output  1  automaton reset.
REQ-012 SHALL have port aut_run  output  1  automaton step enable.
REQ-013 SHALL have port aut_symbols  output  8  symbol presented to the automaton.
REQ-014 SHALL have port aut_report  input  NUM_REPORTS  automaton report outputs, registered inside the automaton.
REQ-015 SHALL have port rpt_valid  output  1  report record available.
REQ-016 SHALL have port rpt_ready  input  1  report record consumed.
REQ-017 SHALL have port rpt_index  output  IDX_W  index of the symbol that caused the report.
REQ-018 SHALL have port rpt_bits  output  NUM_REPORTS  report vector of the record.
REQ-019 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-020 SHALL have port violation  output  1  sticky flag, set by any nonzero report and cleared by trace_start or reset.

Function
REQ-021 SHALL implement FSM states IDLE, RST, RUN and DRAIN.
REQ-022 SHALL move from any state to RST on trace_start.
REQ-023 SHALL hold RST for exactly 2 cycles with aut_reset=1, satisfying both edge-sampled start registers, then enter RUN.
REQ-024 SHALL, on entering RST, flush the symbol FIFO, clear the symbol index to 0, clear violation and drop any pending report.
REQ-025 SHALL drive sym_ready = !fifo_full in RST and RUN, and 0 in IDLE and DRAIN.
REQ-026 SHALL, in RUN or DRAIN, issue a step when the FIFO is non-empty and the report slot can accept a record; the step pops one symbol onto aut_symbols, pulses aut_run for 1 cycle and holds aut_symbols stable during that cycle.
REQ-027 SHALL sample aut_report in the cycle after each aut_run pulse (1-cycle latency) and tag it with that step's index.
REQ-028 SHALL increment the index after every step and saturate it at 2^IDX_W-1.
REQ-029 SHALL push a record only when the sampled aut_report is nonzero; a zero report produces no record.
REQ-030 SHALL hold the record stable while rpt_valid=1 and rpt_ready=0, and SHALL NOT issue a step while the report slot is full.
REQ-031 SHALL keep a symbol written while the FIFO is full and a pop occurs in the same cycle.
REQ-032 SHALL move RUN -> DRAIN on trace_end.
REQ-033 SHALL move DRAIN -> IDLE when the FIFO is empty, no step is in flight and the last report has been sampled.
REQ-034 SHALL give trace_start priority over trace_end when both are asserted in the same cycle.
REQ-035 SHALL ignore trace_end in IDLE and RST.

Reset
REQ-036 SHALL, on reset, set state=IDLE, FIFO empty, index=0, aut_reset=1, aut_run=0, aut_symbols=0, sym_ready=0, rpt_valid=0, rpt_index=0, rpt_bits=0, busy=0 and violation=0.
REQ-037 SHALL hold aut_reset=1 in IDLE and RST, and 0 otherwise.
REQ-038 SHALL discard all in-flight symbols and reports when reset is asserted mid-trace.

Configuration
REQ-039 SHALL, with LTL_SEQ_RPT_FIFO_EN defined, buffer records in a 4-entry report FIFO in front of rpt_*, with the slot counted full only when all 4 entries are occupied.
REQ-040 SHALL, without LTL_SEQ_RPT_FIFO_EN, use a single output register as the report slot.

Verification
REQ-041 SHALL cover: trace_start, then 3 symbols 0x00, 0x08, 0x18, then trace_end -> aut_reset high for 2 cycles, 3 aut_run pulses carrying those symbols in order, then IDLE.
REQ-042 SHALL cover: aut_report=4'b0010 following the step with index 5 -> record {rpt_index=5, rpt_bits=0010} and violation=1.
REQ-043 SHALL cover: rpt_ready held 0 for 10 cycles while reports keep arriving -> steps stall after slot full (1 record, or 4 with LTL_SEQ_RPT_FIFO_EN) and no record is lost.
REQ-044 SHALL cover: 9 symbols offered back-to-back with the report path stalled -> sym_ready=0 after 8 symbols are accepted, and resumes when steps restart.
REQ-045 SHALL cover: trace_start pulsed during RUN with 5 symbols queued -> FIFO flushed, index=0, violation=0, aut_reset high for 2 cycles.
REQ-046 SHALL cover: IDX_W=4 with 20 symbols stepped -> index saturates at 15.
